// File: rtl/sm_decoder_p.sv
// Significance-map decoder: expands one bitmap segment plus its NZVL values into
// a dense pixel stream (zeros re-inserted) or a sparse (index, value) stream.
module sm_decoder_p #(
  parameter int SEG_W  = 16,
  parameter int DATA_W = 16,
  parameter int IDX_W  = $clog2(SEG_W),
  parameter int CNT_W  = $clog2(SEG_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seg_valid,
  output logic              seg_ready,
  input  logic [SEG_W-1:0]  seg_map,
  input  logic [CNT_W-1:0]  seg_hamw,
  input  logic              seg_dense,
  input  logic              nz_valid,
  output logic              nz_ready,
  input  logic [DATA_W-1:0] nz_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [DATA_W-1:0] px_data,
  output logic [IDX_W-1:0]  px_idx,
  output logic              px_last,
  output logic              seg_done,
  output logic              err_hamw,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(SEG_W - 1);

  state_e             state_q, state_d;
  logic [SEG_W-1:0]   map_q, map_d;
  logic               mode_q, mode_d;
  logic [IDX_W-1:0]   pos_q, pos_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [IDX_W-1:0]   cur_idx_s;
  logic               cur_bit_s;
  logic [CNT_W-1:0]   map_cnt_s;

  function automatic logic [CNT_W-1:0] popcount(input logic [SEG_W-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < SEG_W; i++) begin
      c = c + CNT_W'(m[i]);
    end
    return c;
  endfunction

  // Position of the first set bit, MSB first (bit SEG_W-1 is position 0).
  function automatic logic [IDX_W-1:0] first_set(input logic [SEG_W-1:0] m);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int p = SEG_W - 1; p >= 0; p--) begin
      idx = m[SEG_W-1-p] ? IDX_W'(p) : idx;
    end
    return idx;
  endfunction

  assign busy = (state_q != ST_IDLE);

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    map_d     = map_q;
    mode_d    = mode_q;
    pos_d     = pos_q;
    rem_d     = rem_q;
    seg_ready = 1'b0;
    nz_ready  = 1'b0;
    px_valid  = 1'b0;
    px_data   = '0;
    px_idx    = '0;
    px_last   = 1'b0;
    seg_done  = 1'b0;
    err_hamw  = 1'b0;
    map_cnt_s = popcount(seg_map);
    cur_idx_s = mode_q ? pos_q : first_set(map_q);
    cur_bit_s = map_q[LAST_POS - cur_idx_s];
    case (state_q)
      ST_IDLE: begin
        // rst_n gating keeps seg_ready low while reset is held.
        seg_ready = rst_n;
        if (seg_valid && rst_n) begin
          map_d    = seg_map;
          mode_d   = seg_dense;
          pos_d    = '0;
          rem_d    = map_cnt_s;
          err_hamw = (seg_hamw != map_cnt_s);
          state_d  = (!seg_dense && (seg_map == '0)) ? ST_DONE : ST_EMIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        px_idx = cur_idx_s;
        if (cur_bit_s) begin
          px_valid = nz_valid;
          px_data  = nz_data;
          nz_ready = px_ready;
        end else begin
          px_valid = 1'b1;
          px_data  = '0;
          nz_ready = 1'b0;
        end
        px_last = mode_q ? (pos_q == LAST_POS) : (rem_q == CNT_W'(1));
        if (px_valid && px_ready) begin
          if (cur_bit_s && (rem_q != '0)) begin
            rem_d = rem_q - CNT_W'(1);
          end else begin
            rem_d = rem_q;
          end
          if (mode_q) begin
            pos_d = (pos_q != LAST_POS) ? pos_q + IDX_W'(1) : pos_q;
          end else begin
            pos_d = cur_idx_s;
            map_d[LAST_POS - cur_idx_s] = 1'b0;
          end
          state_d = px_last ? ST_DONE : ST_EMIT;
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_DONE: begin
        seg_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, working map, position, remaining count and mode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      map_q   <= '0;
      mode_q  <= 1'b0;
      pos_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      mode_q  <= mode_d;
      pos_q   <= pos_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_sm_decoder_p.sv
// Randomized bench for sm_decoder_p: a queue-based model derives the expected
// pixel stream of each segment straight from the map and the NZVL values.
module tb_sm_decoder_p;
  localparam int SEG_W  = 16;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 4;
  localparam int CNT_W  = 5;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic              last;
  } px_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic seg_valid = 1'b0, seg_dense = 1'b0, nz_valid = 1'b0, px_ready = 1'b0;
  logic [SEG_W-1:0] seg_map = '0;
  logic [CNT_W-1:0] seg_hamw = '0;
  logic [DATA_W-1:0] nz_data = '0;
  logic seg_ready, nz_ready, px_valid, px_last, seg_done, err_hamw, busy;
  logic [DATA_W-1:0] px_data;
  logic [IDX_W-1:0] px_idx;

  always #5 clk = ~clk;

  sm_decoder_p #(.SEG_W(SEG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_map(seg_map),
    .seg_hamw(seg_hamw), .seg_dense(seg_dense),
    .nz_valid(nz_valid), .nz_ready(nz_ready), .nz_data(nz_data),
    .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
    .px_idx(px_idx), .px_last(px_last), .seg_done(seg_done),
    .err_hamw(err_hamw), .busy(busy)
  );

  int total = 0, bad = 0;
  int cyc = 0;
  logic [DATA_W-1:0] nzq[$];
  logic [DATA_W-1:0] vals[$];
  px_t got[$], expq[$], ref_run[$];
  int stall_px = 0, stall_nz = 0;
  bit nzv_hold = 1'b0, seg_pending = 1'b0;
  int nz_xfers, err_cnt, gap_cnt, stab_bad, nzonly_bad;
  int acc_cyc, done_cyc, first_cyc, prev_acc;
  logic err_at_acc;
  logic p_pv, p_pr;
  logic [DATA_W-1:0] p_data;
  logic [IDX_W-1:0] p_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 2 ns later, the edge commits.
  task automatic step();
    px_t e;
    @(negedge clk);
    seg_valid = seg_pending;
    if (!nzv_hold) nz_valid = (nzq.size() > 0) && ($urandom_range(99) >= stall_nz);
    nz_data  = (nzq.size() > 0) ? nzq[0] : DATA_W'($urandom);
    px_ready = ($urandom_range(99) >= stall_px);
    #2;
    cyc++;
    if (p_pv && !p_pr && !(px_valid && px_data == p_data && px_idx == p_idx)) stab_bad++;
    if (nz_valid && nz_ready && !(px_valid && px_ready)) nzonly_bad++;
    if (err_hamw) err_cnt++;
    if (busy && !seg_done && !px_valid) gap_cnt++;
    if (px_valid && first_cyc < 0) first_cyc = cyc;
    if (seg_valid && seg_ready) begin
      seg_pending = 1'b0;
      acc_cyc = cyc;
      err_at_acc = err_hamw;
    end
    if (px_valid && px_ready) begin
      e.idx = px_idx; e.data = px_data; e.last = px_last;
      got.push_back(e);
    end
    if (nz_valid && nz_ready) begin
      nz_xfers++;
      void'(nzq.pop_front());
    end
    nzv_hold = nz_valid && !nz_ready;
    p_pv = px_valid; p_pr = px_ready; p_data = px_data; p_idx = px_idx;
  endtask

  task automatic do_abort(input string nm);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk({nm, " rst ctl"}, {25'd0, px_valid, nz_ready, seg_ready, busy, px_last, seg_done, err_hamw}, 32'd0);
    chk({nm, " rst data"}, {12'd0, px_idx, px_data}, 32'd0);
    @(negedge clk);
    chk({nm, " rst nz_ready"}, {31'd0, nz_ready}, 32'd0);
    nzq.delete(); nz_valid = 1'b0; nzv_hold = 1'b0; seg_pending = 1'b0; seg_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk({nm, " seg_ready after release"}, {31'd0, seg_ready}, 32'd1);
  endtask

  task automatic run_seg(input logic [SEG_W-1:0] map, input logic [CNT_W-1:0] hamw,
                         input bit dense, input bit reuse, input int abort_after, input string nm);
    int n, k, waitc;
    bit seen_done;
    px_t e;
    n = $countones(map);
    if (!reuse) begin
      vals.delete();
      for (int i = 0; i < n; i++) vals.push_back(DATA_W'($urandom));
    end
    foreach (vals[i]) nzq.push_back(vals[i]);
    expq.delete();
    k = 0;
    for (int p = 0; p < SEG_W; p++) begin
      e.idx = IDX_W'(p);
      e.last = 1'b0;
      if (map[SEG_W-1-p]) begin
        e.data = vals[k];
        k++;
      end else begin
        e.data = '0;
      end
      if (dense || map[SEG_W-1-p]) expq.push_back(e);
    end
    if (expq.size() > 0) begin
      e = expq.pop_back();
      e.last = 1'b1;
      expq.push_back(e);
    end
    got.delete();
    nz_xfers = 0; err_cnt = 0; gap_cnt = 0; stab_bad = 0; nzonly_bad = 0;
    first_cyc = -1; p_pv = 1'b0; acc_cyc = -1; done_cyc = -1;
    seg_map = map; seg_hamw = hamw; seg_dense = dense; seg_pending = 1'b1;
    waitc = 0;
    while (seg_pending && waitc < 100) begin
      step();
      waitc++;
    end
    if (seg_pending) begin
      chk({nm, " accept timeout"}, 32'd0, 32'd1);
      seg_pending = 1'b0;
      return;
    end
    seen_done = 1'b0;
    waitc = 0;
    while (!seen_done && waitc < 3000) begin
      step();
      waitc++;
      if (abort_after > 0 && got.size() == abort_after) begin
        do_abort(nm);
        return;
      end
      if (seg_done) begin
        seen_done = 1'b1;
        done_cyc = cyc;
      end
    end
    if (!seen_done) chk({nm, " done timeout"}, 32'd0, 32'd1);
    chk({nm, " count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      chk($sformatf("%s px%0d", nm, i), 32'(got[i]), 32'(expq[i]));
    chk({nm, " nz xfers"}, nz_xfers, n);
    chk({nm, " err_hamw pulses"}, err_cnt, (int'(hamw) != n) ? 1 : 0);
    chk({nm, " err_hamw at accept"}, {31'd0, err_at_acc}, (int'(hamw) != n) ? 1 : 0);
    chk({nm, " stall stability"}, stab_bad, 0);
    chk({nm, " nz without px"}, nzonly_bad, 0);
  endtask

  initial begin
    logic [SEG_W-1:0] m;
    int mism;
    #12;
    chk("reset ctl", {25'd0, px_valid, nz_ready, seg_ready, busy, px_last, seg_done, err_hamw}, 32'd0);
    chk("reset data", {12'd0, px_idx, px_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("seg_ready after release", {31'd0, seg_ready}, 32'd1);

    vals.delete(); vals.push_back(16'h1111); vals.push_back(16'h2222);
    run_seg(16'hA000, 5'd2, 1'b1, 1'b1, 0, "dense A000");
    chk("dense A000 first latency", first_cyc - acc_cyc, 1);
    chk("dense A000 done latency", done_cyc - acc_cyc, SEG_W + 1);
    chk("dense A000 gaps", gap_cnt, 0);

    run_seg(16'h8001, 5'd2, 1'b0, 1'b0, 0, "sparse 8001");
    chk("sparse 8001 first latency", first_cyc - acc_cyc, 1);
    chk("sparse 8001 done latency", done_cyc - acc_cyc, 3);
    chk("sparse 8001 gaps", gap_cnt, 0);

    run_seg(16'h0000, 5'd0, 1'b0, 1'b0, 0, "sparse zero a");
    chk("sparse zero done latency", done_cyc - acc_cyc, 1);
    prev_acc = acc_cyc;
    run_seg(16'h0000, 5'd0, 1'b0, 1'b0, 0, "sparse zero b");
    chk("sparse zero back-to-back", acc_cyc - prev_acc, 2);

    run_seg(16'hFFFF, 5'd16, 1'b1, 1'b0, 0, "dense FFFF clean");
    ref_run = got;
    stall_px = 40; stall_nz = 40;
    run_seg(16'hFFFF, 5'd16, 1'b1, 1'b1, 0, "dense FFFF stalled");
    mism = 0;
    for (int i = 0; i < ref_run.size() && i < got.size(); i++)
      if (got[i] !== ref_run[i]) mism++;
    chk("stalled vs clean size", got.size(), ref_run.size());
    chk("stalled vs clean data", mism, 0);
    stall_px = 0; stall_nz = 0;

    run_seg(16'h0003, 5'd3, 1'b0, 1'b0, 0, "sparse 0003 bad hamw");

    run_seg(16'hF0F0, 5'd8, 1'b1, 1'b0, 5, "dense abort");
    run_seg(16'h9C31, 5'd7, 1'b1, 1'b0, 0, "dense after reset");
    chk("after reset first idx", {28'd0, got.size() > 0 ? got[0].idx : 4'hF}, 32'd0);

    for (int t = 0; t < 10; t++) begin
      m = ($urandom_range(5) == 0) ? 16'h0000 : SEG_W'($urandom);
      stall_px = $urandom_range(50);
      stall_nz = $urandom_range(50);
      run_seg(m, ($urandom_range(4) == 0) ? CNT_W'($countones(m) ^ 1) : CNT_W'($countones(m)),
              1'($urandom_range(1)), 1'b0, 0, $sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
